// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter with bounded burst ownership for one RAM port,
// steering the one-cycle-latency read data back to the requester that issued the read.
module ram_port_arbiter #(
   parameter int MEMORY_WIDTH = 32,
   parameter int NUM_REQ = 2,
   parameter int MAX_BURST = 4,
   parameter logic [MEMORY_WIDTH-1:0] ADDR_MASK = 'h0000FFFF
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_in,
   input  logic [NUM_REQ*MEMORY_WIDTH-1:0] addr_in,
   input  logic [NUM_REQ*MEMORY_WIDTH-1:0] data_in,
   input  logic [NUM_REQ*4-1:0]            wb_in,
   output logic [NUM_REQ-1:0]              gnt_out,
   output logic [NUM_REQ-1:0]              rvalid_out,
   output logic [MEMORY_WIDTH-1:0]         rdata_out,
   output logic                            mem_enable_out,
   output logic [MEMORY_WIDTH-1:0]         mem_addr_out,
   output logic [MEMORY_WIDTH-1:0]         mem_data_out,
   output logic [3:0]                      mem_wb_out,
   input  logic [MEMORY_WIDTH-1:0]         mem_data_in
);
   localparam logic [0:0] IDLE = 1'b0, OWNED = 1'b1;
   logic [0:0] state;
   logic [1:0] owner, last_owner, rd_id, g;
   logic [3:0] burst_cnt;
   logic rd_pend, hit, keep, others;
   logic [NUM_REQ-1:0] own_mask;
   // First requester after base, wrapping modulo NUM_REQ; base itself is checked last.
   function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [NUM_REQ-1:0] req);
      logic [1:0] w, j;
      w = base;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = 2'((int'(base) + k) % NUM_REQ);
         if (req[j]) w = j;
      end
      return w;
   endfunction
   // Grants are combinational and suppressed while reset is held so every output stays 0.
   always_comb begin
      own_mask = NUM_REQ'(1) << owner;
      others = |(req_in & ~own_mask);
      hit = reset && |req_in;
      keep = state == OWNED && req_in[owner] && (burst_cnt < 4'(MAX_BURST) || !others);
      g = keep ? owner : rr_pick(state == OWNED ? owner : last_owner, req_in);
      gnt_out = hit ? NUM_REQ'(1) << g : '0;
      mem_enable_out = hit;
      mem_addr_out = hit ? addr_in[int'(g)*MEMORY_WIDTH +: MEMORY_WIDTH] & ADDR_MASK : '0;
      mem_data_out = hit ? data_in[int'(g)*MEMORY_WIDTH +: MEMORY_WIDTH] : '0;
      mem_wb_out = hit ? wb_in[int'(g)*4 +: 4] : 4'b0;
      rvalid_out = rd_pend ? NUM_REQ'(1) << rd_id : '0;
      rdata_out = rd_pend ? mem_data_in : '0;
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         owner <= 2'd0;
         last_owner <= 2'(NUM_REQ - 1);
         burst_cnt <= 4'd0;
         rd_pend <= 1'b0;
         rd_id <= 2'd0;
      end else begin
         rd_pend <= hit && mem_wb_out == 4'b0;
         rd_id <= g;
         if (!hit) begin
            state <= IDLE;
            if (state == OWNED) last_owner <= owner;
         end else begin
            state <= OWNED;
            owner <= g;
            if (keep) burst_cnt <= burst_cnt < 4'(MAX_BURST) ? burst_cnt + 4'd1 : 4'd1;
            else begin
               burst_cnt <= 4'd1;
               if (state == OWNED) last_owner <= owner;
            end
         end
      end
   end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of ram_port_arbiter against a
// behavioural model of the round-robin / burst / read-return rules.
module tb_ram_port_arbiter;
   localparam int N = 2;
   localparam int MAXB = 4;
   logic clock = 1'b0;
   logic reset;
   logic [N-1:0] req;
   logic [31:0] addr [N];
   logic [31:0] data [N];
   logic [3:0] wb [N];
   logic [31:0] mdin;
   logic [N-1:0] gnt_out, rvalid_out;
   logic [31:0] rdata_out, mem_addr_out, mem_data_out;
   logic mem_enable_out;
   logic [3:0] mem_wb_out;
   int total = 0, bad = 0;
   int m_idle, m_owner, m_last, m_run, m_rdp, m_rd_id, cur_g;
   logic [1:0] pat [9];

   always #5 clock = ~clock;

   ram_port_arbiter dut (
      .clock(clock), .reset(reset), .req_in(req),
      .addr_in({addr[1], addr[0]}), .data_in({data[1], data[0]}), .wb_in({wb[1], wb[0]}),
      .gnt_out(gnt_out), .rvalid_out(rvalid_out), .rdata_out(rdata_out),
      .mem_enable_out(mem_enable_out), .mem_addr_out(mem_addr_out),
      .mem_data_out(mem_data_out), .mem_wb_out(mem_wb_out), .mem_data_in(mdin)
   );

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, o, e);
      end
   endtask

   function automatic int exp_pick();
      int oth, j;
      oth = 0;
      if (req == '0) return -1;
      for (int i = 0; i < N; i++) if (i != m_owner && req[i]) oth = 1;
      if (m_idle == 0 && req[m_owner] && (m_run < MAXB || oth == 0)) return m_owner;
      for (int k = 1; k <= N; k++) begin
         j = ((m_idle != 0 ? m_last : m_owner) + k) % N;
         if (req[j]) return j;
      end
      return -1;
   endfunction

   task automatic chk_now();
      logic [31:0] e_gnt, e_rv;
      #1;
      if (!reset) begin
         m_idle = 1; m_owner = 0; m_last = N - 1; m_run = 0; m_rdp = 0; m_rd_id = 0;
      end
      cur_g = reset ? exp_pick() : -1;
      e_gnt = cur_g < 0 ? 32'd0 : 32'd1 << cur_g;
      e_rv = m_rdp != 0 ? 32'd1 << m_rd_id : 32'd0;
      chk("gnt", 32'(gnt_out), e_gnt);
      chk("mem_en", 32'(mem_enable_out), cur_g >= 0 ? 32'd1 : 32'd0);
      chk("mem_addr", mem_addr_out, cur_g < 0 ? 32'd0 : addr[cur_g] & 32'h0000FFFF);
      chk("mem_data", mem_data_out, cur_g < 0 ? 32'd0 : data[cur_g]);
      chk("mem_wb", 32'(mem_wb_out), cur_g < 0 ? 32'd0 : 32'(wb[cur_g]));
      chk("rvalid", 32'(rvalid_out), e_rv);
      chk("rdata", rdata_out, m_rdp != 0 ? mdin : 32'd0);
   endtask

   task automatic adv();
      @(posedge clock);
      if (reset) begin
         m_rdp = (cur_g >= 0 && wb[cur_g] == 4'b0) ? 1 : 0;
         m_rd_id = cur_g < 0 ? 0 : cur_g;
         if (cur_g < 0) begin
            if (m_idle == 0) m_last = m_owner;
            m_idle = 1;
         end else if (m_idle == 0 && cur_g == m_owner) m_run = m_run < MAXB ? m_run + 1 : 1;
         else begin
            if (m_idle == 0) m_last = m_owner;
            m_owner = cur_g; m_run = 1; m_idle = 0;
         end
      end
      @(negedge clock);
   endtask

   initial begin
      pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
      reset = 1'b0; req = 2'b11; mdin = 32'h5555AAAA;
      for (int i = 0; i < N; i++) begin addr[i] = 32'h100 * i; data[i] = 32'hA0 + i; wb[i] = 4'b0; end
      @(negedge clock);
      // reset holds all outputs low despite requests
      for (int i = 0; i < 2; i++) begin chk_now(); adv(); end
      reset = 1'b1;
      // burst limit with both requesting, requester 0 first
      for (int i = 0; i < 9; i++) begin chk_now(); chk("burst_seq", 32'(gnt_out), 32'(pat[i])); adv(); end
      req = 2'b00; chk_now(); adv();
      // single read
      req = 2'b01; addr[0] = 32'h40000010; wb[0] = 4'b0;
      chk_now(); chk("rd_addr", mem_addr_out, 32'h00000010); adv();
      req = 2'b00; mdin = 32'hDEADBEEF;
      chk_now(); chk("rd_valid", 32'(rvalid_out), 32'd1); chk("rd_data", rdata_out, 32'hDEADBEEF); adv();
      // solo streaming by requester 1
      req = 2'b10; wb[1] = 4'b1111;
      for (int i = 0; i < 10; i++) begin chk_now(); chk("solo", 32'(gnt_out), 32'd2); adv(); end
      // write then read
      req = 2'b01; wb[0] = 4'b0011; data[0] = 32'h1234;
      chk_now(); chk("wr_wb", 32'(mem_wb_out), 32'h3); adv();
      req = 2'b10; wb[1] = 4'b0;
      chk_now(); chk("wr_no_rv", 32'(rvalid_out), 32'd0); adv();
      req = 2'b00;
      chk_now(); chk("rd1_rv", 32'(rvalid_out), 32'd2); adv();
      // reset right after a granted read
      req = 2'b01; wb[0] = 4'b0;
      chk_now(); adv();
      reset = 1'b0; req = 2'b00;
      chk_now(); chk("rst_rv", 32'(rvalid_out), 32'd0); adv();
      reset = 1'b1;
      chk_now(); chk("post_rst_rv", 32'(rvalid_out), 32'd0); adv();
      req = 2'b11;
      chk_now(); chk("post_rst_gnt", 32'(gnt_out), 32'd1); adv();
      // random traffic; ungranted requesters hold request and payload
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(req[i] && cur_g != i)) begin
               req[i] = 1'($urandom_range(0, 3) != 0);
               addr[i] = $urandom; data[i] = $urandom;
               wb[i] = $urandom_range(0, 1) != 0 ? 4'($urandom) : 4'b0;
            end
         end
         mdin = $urandom;
         chk_now(); adv();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
